// File: rtl/pea_pkg.sv
// Shared PE types: FU opcode set, issue-sequencer state and vector-mode encodings,
// plus the lane-wise adder used by the result accumulator.
package pea_pkg;

  typedef enum logic [3:0] {
    FU_NOP = 4'd0,
    FU_ADD = 4'd1,
    FU_SUB = 4'd2,
    FU_MUL = 4'd3,
    FU_AND = 4'd4,
    FU_OR  = 4'd5,
    FU_XOR = 4'd6,
    FU_SHL = 4'd7
  } fu_instr_t;

  typedef enum logic {
    SEQ_IDLE     = 1'b0,
    SEQ_MUL_HOLD = 1'b1
  } fu_seq_state_t;

  localparam logic [1:0] VEC_MODE_32 = 2'b00;
  localparam logic [1:0] VEC_MODE_8  = 2'b01;
  localparam logic [1:0] VEC_MODE_16 = 2'b10;

  // Carries never cross lane boundaries; each lane wraps on its own width.
  function automatic logic [31:0] lane_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] mode);
    logic [31:0] s;
    s = '0;
    case (mode)
      VEC_MODE_8: begin
        for (int i = 0; i < 4; i++) s[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
      end
      VEC_MODE_16: begin
        for (int i = 0; i < 2; i++) s[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
      end
      default: s = a + b;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pe_result_fifo.sv
// Small circular result buffer with occupancy count; pop on empty is ignored.
module pe_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   valid_o,
  output logic [W-1:0]           data_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push_i && !do_pop && (count_q == CW'(DEPTH))));
  end

endmodule

// File: rtl/fu_issue_seq.sv
// Issue sequencer around the partitioned FU: drives instr/mode, stretches 32-bit MUL
// to two cycles, optionally accumulates lane-wise, and buffers results for the consumer.
module fu_issue_seq
  import pea_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  fu_instr_t         issue_instr_i,
  input  logic [1:0]        issue_vec_mode_i,
  input  logic              issue_acc_en_i,
  input  logic              issue_acc_clr_i,
  output fu_instr_t         fu_instr_o,
  output logic [1:0]        fu_vec_mode_o,
  input  logic [DATA_W-1:0] fu_res_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o
);
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  fu_seq_state_t     state_q, state_d;
  logic              hold_acc_en_q, hold_acc_clr_q;
  logic [1:0]        hold_mode_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     fifo_count, pending;
  logic              accept, is_mul32, capture, pop;
  logic              cap_acc_en, cap_acc_clr;
  logic [1:0]        cap_mode;
  logic [DATA_W-1:0] push_data;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid, and a same-cycle pop does not raise issue ready.
  assign pending       = (state_q == SEQ_MUL_HOLD) ? CW'(1) : '0;
  assign issue_ready_o = (state_q == SEQ_IDLE) && ((fifo_count + pending) < CW'(OUT_DEPTH));
  assign accept        = issue_valid_i && issue_ready_o;
  assign is_mul32      = (issue_instr_i == FU_MUL) && (issue_vec_mode_i == VEC_MODE_32);
  assign pop           = out_valid_o && out_ready_i;
  assign busy_o        = (state_q != SEQ_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= SEQ_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:     if (accept && is_mul32) state_d = SEQ_MUL_HOLD;
      SEQ_MUL_HOLD: state_d = SEQ_IDLE;
      default:      state_d = SEQ_IDLE;
    endcase
  end

  // In MUL_HOLD the FU sees the latched MUL/32b op while it combines partial products.
  always_comb begin
    fu_instr_o    = FU_NOP;
    fu_vec_mode_o = VEC_MODE_32;
    capture       = 1'b0;
    cap_acc_en    = issue_acc_en_i;
    cap_acc_clr   = issue_acc_clr_i;
    cap_mode      = issue_vec_mode_i;
    case (state_q)
      SEQ_IDLE: begin
        if (issue_valid_i) begin
          fu_instr_o    = issue_instr_i;
          fu_vec_mode_o = issue_vec_mode_i;
        end
        capture = accept && (issue_instr_i != FU_NOP) && !is_mul32;
      end
      SEQ_MUL_HOLD: begin
        fu_instr_o    = FU_MUL;
        fu_vec_mode_o = VEC_MODE_32;
        capture       = 1'b1;
        cap_acc_en    = hold_acc_en_q;
        cap_acc_clr   = hold_acc_clr_q;
        cap_mode      = hold_mode_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    push_data = fu_res_i;
    if (capture) begin
      if (cap_acc_en) begin
        push_data = lane_add(cap_acc_clr ? '0 : acc_q, fu_res_i, cap_mode);
        acc_d     = push_data;
      end else if (cap_acc_clr) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q          <= '0;
      hold_acc_en_q  <= 1'b0;
      hold_acc_clr_q <= 1'b0;
      hold_mode_q    <= VEC_MODE_32;
    end else begin
      acc_q <= acc_d;
      if (accept && is_mul32) begin
        hold_acc_en_q  <= issue_acc_en_i;
        hold_acc_clr_q <= issue_acc_clr_i;
        hold_mode_q    <= issue_vec_mode_i;
      end
    end
  end

  pe_result_fifo #(.DEPTH(OUT_DEPTH), .W(DATA_W)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (capture),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .valid_o     (out_valid_o),
    .data_o      (out_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (DATA_W == 32);
  end

endmodule

// File: tb/tb_fu_issue_seq.sv
// Bench for fu_issue_seq: directed scenarios plus random traffic against a queue-based model.
module tb_fu_issue_seq;
  import pea_pkg::*;

  localparam int OUT_DEPTH = 2;

  logic        clk, rst;
  logic        issue_valid, issue_ready_o;
  fu_instr_t   issue_instr;
  logic [1:0]  issue_vec_mode;
  logic        issue_acc_en, issue_acc_clr;
  fu_instr_t   fu_instr_o;
  logic [1:0]  fu_vec_mode_o;
  logic [31:0] fu_res;
  logic        out_valid_o, out_ready;
  logic [31:0] out_data_o;
  logic        busy_o;

  fu_issue_seq #(.OUT_DEPTH(OUT_DEPTH), .DATA_W(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready_o),
    .issue_instr_i    (issue_instr),
    .issue_vec_mode_i (issue_vec_mode),
    .issue_acc_en_i   (issue_acc_en),
    .issue_acc_clr_i  (issue_acc_clr),
    .fu_instr_o       (fu_instr_o),
    .fu_vec_mode_o    (fu_vec_mode_o),
    .fu_res_i         (fu_res),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready),
    .out_data_o       (out_data_o),
    .busy_o           (busy_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Scoreboard and reference model state
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  bit          m_hold;
  logic        m_ae, m_ac;
  logic [1:0]  m_md;
  logic [31:0] m_acc;
  logic        exp_rdy;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Lane sum from the arithmetic definition: each lane is (a_lane + b_lane) mod 2^w.
  function automatic logic [31:0] m_lane_add(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] md);
    longint w, modv, la, lb, r;
    w    = (md == 2'b01) ? 8 : (md == 2'b10) ? 16 : 32;
    modv = longint'(1) << w;
    r    = 0;
    for (int i = 0; i < 32 / int'(w); i++) begin
      la = (longint'(a) >> (i * w)) % modv;
      lb = (longint'(b) >> (i * w)) % modv;
      r  = r + (((la + lb) % modv) << (i * w));
    end
    return 32'(r);
  endfunction

  task automatic m_capture(input logic ae, input logic ac, input logic [1:0] md,
                           input logic [31:0] res);
    logic [31:0] v;
    if (ae) begin
      v     = m_lane_add(ac ? 32'd0 : m_acc, res, md);
      m_acc = v;
      exp_q.push_back(v);
    end else begin
      if (ac) m_acc = 32'd0;
      exp_q.push_back(res);
    end
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_hold = 1'b0;
    m_acc  = 32'd0;
    m_ae   = 1'b0;
    m_ac   = 1'b0;
    m_md   = 2'b00;
  endtask

  task automatic check_outputs();
    exp_rdy = !m_hold && (exp_q.size() < OUT_DEPTH);
    check("issue_ready", 32'(issue_ready_o), 32'(exp_rdy));
    check("fu_instr", 32'(fu_instr_o), 32'(m_hold ? FU_MUL : (issue_valid ? issue_instr : FU_NOP)));
    check("fu_mode", 32'(fu_vec_mode_o), 32'(m_hold ? 2'b00 : (issue_valid ? issue_vec_mode : 2'b00)));
    check("out_valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_data", out_data_o, exp_q[0]);
    check("busy", 32'(busy_o), 32'(m_hold || (exp_q.size() != 0)));
  endtask

  task automatic model_step();
    logic do_pop, acc;
    do_pop = (exp_q.size() != 0) && out_ready;
    acc    = issue_valid && exp_rdy;
    if (do_pop) void'(exp_q.pop_front());
    if (m_hold) begin
      m_capture(m_ae, m_ac, m_md, fu_res);
      m_hold = 1'b0;
    end else if (acc && issue_instr != FU_NOP) begin
      if (issue_instr == FU_MUL && issue_vec_mode == 2'b00) begin
        m_hold = 1'b1;
        m_ae   = issue_acc_en;
        m_ac   = issue_acc_clr;
        m_md   = issue_vec_mode;
      end else begin
        m_capture(issue_acc_en, issue_acc_clr, issue_vec_mode, fu_res);
      end
    end
  endtask

  // Driver: apply inputs at negedge, check settled outputs, then advance the model at posedge.
  task automatic drive(input logic v, input fu_instr_t ins, input logic [1:0] md,
                       input logic ae, input logic ac, input logic [31:0] res,
                       input logic ordy);
    @(negedge clk);
    issue_valid    = v;
    issue_instr    = ins;
    issue_vec_mode = md;
    issue_acc_en   = ae;
    issue_acc_clr  = ac;
    fu_res         = res;
    out_ready      = ordy;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, FU_NOP, 2'b00, 1'b0, 1'b0, 32'd0, ordy);
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_instr = FU_NOP; issue_vec_mode = 2'b00;
    issue_acc_en = 1'b0; issue_acc_clr = 1'b0; fu_res = 32'd0; out_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_fu_instr", 32'(fu_instr_o), 32'(FU_NOP));
    check("rst_fu_mode", 32'(fu_vec_mode_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_data", out_data_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle ADD: result visible one cycle after issue
    drive(1'b1, FU_ADD, 2'b00, 1'b0, 1'b0, 32'h0000_000C, 1'b1);
    #1;
    check("add_valid", 32'(out_valid_o), 32'd1);
    check("add_data", out_data_o, 32'h0000_000C);

    // MUL32: held for two cycles, result two cycles after issue
    drive(1'b1, FU_MUL, 2'b00, 1'b0, 1'b0, 32'h0000_1234, 1'b1);
    #1;
    check("mul_no_early", 32'(out_valid_o), 32'd0);
    drive(1'b0, FU_NOP, 2'b00, 1'b0, 1'b0, 32'h0006_0000, 1'b1);
    #1;
    check("mul_data", out_data_o, 32'h0006_0000);

    // 8-bit lanes: clear then accumulate, lane 0 wraps without carry
    drive(1'b1, FU_ADD, 2'b01, 1'b1, 1'b1, 32'h0000_00FF, 1'b1);
    #1;
    check("vec8_first", out_data_o, 32'h0000_00FF);
    drive(1'b1, FU_ADD, 2'b01, 1'b1, 1'b0, 32'h0101_0101, 1'b1);
    #1;
    check("vec8_second", out_data_o, 32'h0101_0100);
    idle(1'b1);

    // Backpressure: fill the FIFO, stall, then drain in order
    drive(1'b1, FU_ADD, 2'b00, 1'b0, 1'b0, 32'h11, 1'b0);
    drive(1'b1, FU_ADD, 2'b00, 1'b0, 1'b0, 32'h22, 1'b0);
    #1;
    check("full_ready", 32'(issue_ready_o), 32'd0);
    check("full_head", out_data_o, 32'h11);
    drive(1'b1, FU_ADD, 2'b00, 1'b0, 1'b0, 32'h33, 1'b0);
    drive(1'b1, FU_ADD, 2'b00, 1'b0, 1'b0, 32'h33, 1'b1);
    #1;
    check("drain_b", out_data_o, 32'h22);
    drive(1'b1, FU_ADD, 2'b00, 1'b0, 1'b0, 32'h33, 1'b1);
    idle(1'b1);

    // Reset during MUL_HOLD discards the op and clears the accumulator
    drive(1'b1, FU_ADD, 2'b00, 1'b1, 1'b0, 32'h0000_0100, 1'b1);
    drive(1'b1, FU_MUL, 2'b00, 1'b1, 1'b0, 32'h0000_0005, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    issue_valid = 1'b0;
    #1;
    m_reset();
    check("rstmul_fu_instr", 32'(fu_instr_o), 32'(FU_NOP));
    check("rstmul_out_valid", 32'(out_valid_o), 32'd0);
    check("rstmul_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, FU_ADD, 2'b00, 1'b1, 1'b0, 32'h0000_0007, 1'b1);
    #1;
    check("acc_after_rst", out_data_o, 32'h0000_0007);

    // NOP: accepted, no output
    drive(1'b1, FU_NOP, 2'b00, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    #1;
    check("nop_valid", 32'(out_valid_o), 32'd0);
    check("nop_busy", 32'(busy_o), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), fu_instr_t'($urandom_range(0, 7)),
            2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), $urandom(),
            1'($urandom_range(0, 3) != 0));
    end
    for (int n = 0; n < 4; n++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
